// File: rtl/adc_dly_calib_ctrl_if.sv
// rtl/adc_dly_calib_ctrl_if.sv - control, sample and delay-load bundle of the ADC delay calibration sequencer
interface adc_dly_calib_ctrl_if #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int TAP_WIDTH      = 5
);
  logic                      start_i;
  logic [ADC_DATA_WIDTH-1:0] adc_data_i;
  logic [TAP_WIDTH-1:0]      dly_tap_o;
  logic [ADC_DATA_WIDTH-1:0] dly_ld_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      locked_o;
  logic [ADC_DATA_WIDTH-1:0] fail_o;
`ifdef ADC_DLY_CALIB_WIN_REPORT_EN
  logic [ADC_DATA_WIDTH*(TAP_WIDTH+1)-1:0] win_len_o;

  modport master (
    input  start_i, adc_data_i,
    output dly_tap_o, dly_ld_o, busy_o, done_o, locked_o, fail_o, win_len_o
  );
  modport slave (
    output start_i, adc_data_i,
    input  dly_tap_o, dly_ld_o, busy_o, done_o, locked_o, fail_o, win_len_o
  );
`else
  modport master (
    input  start_i, adc_data_i,
    output dly_tap_o, dly_ld_o, busy_o, done_o, locked_o, fail_o
  );
  modport slave (
    output start_i, adc_data_i,
    input  dly_tap_o, dly_ld_o, busy_o, done_o, locked_o, fail_o
  );
`endif
endinterface

// File: rtl/adc_dly_calib_ctrl.sv
// rtl/adc_dly_calib_ctrl.sv - per-lane IDELAY tap sweep and window-centre calibration (option: ADC_DLY_CALIB_WIN_REPORT_EN)
module adc_dly_calib_ctrl #(
  parameter int                        ADC_DATA_WIDTH = 8,
  parameter int                        TAP_WIDTH      = 5,
  parameter int                        NUM_TAPS       = 32,
  parameter int                        SETTLE_CYC     = 16,
  parameter int                        SAMPLE_CNT     = 256,
  parameter logic [ADC_DATA_WIDTH-1:0] TRAIN_PATTERN  = 8'hA5
) (
  input logic                  clk,
  input logic                  rst,
  adc_dly_calib_ctrl_if.master bus
);

  localparam int LW     = TAP_WIDTH + 1;
  localparam int LANE_W = (ADC_DATA_WIDTH > 1) ? $clog2(ADC_DATA_WIDTH) : 1;
  localparam int SCW    = $clog2(SETTLE_CYC + 1);
  localparam int NCW    = $clog2(SAMPLE_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_CENTER, S_NEXT, S_DONE
  } state_t;

  state_t               state;
  logic [LANE_W-1:0]    lane;
  logic [TAP_WIDTH-1:0] tap;
  logic [SCW-1:0]       settle_cnt;
  logic [NCW-1:0]       sample_cnt;
  logic                 err;
  logic [TAP_WIDTH-1:0] cur_start, best_start;
  logic [LW-1:0]        cur_len, best_len;

  logic [TAP_WIDTH-1:0] nxt_cur_start, nxt_best_start;
  logic [LW-1:0]        nxt_cur_len, nxt_best_len;

  // Window bookkeeping for the tap just checked; EVAL commits it and the
  // centre load uses it directly so the last tap's result is included.
  always_comb begin
    nxt_cur_start  = cur_start;
    nxt_cur_len    = cur_len;
    nxt_best_start = best_start;
    nxt_best_len   = best_len;
    if (!err) begin
      if (cur_len == '0) nxt_cur_start = tap;
      nxt_cur_len = cur_len + 1'b1;
      if (nxt_cur_len > best_len) begin
        nxt_best_start = nxt_cur_start;
        nxt_best_len   = nxt_cur_len;
      end
    end else begin
      nxt_cur_len = '0;
    end
  end

  // Sequencer: all outputs are registered on the transition into the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lane          <= '0;
      tap           <= '0;
      settle_cnt    <= '0;
      sample_cnt    <= '0;
      err           <= 1'b0;
      cur_start     <= '0;
      cur_len       <= '0;
      best_start    <= '0;
      best_len      <= '0;
      bus.dly_tap_o <= '0;
      bus.dly_ld_o  <= '0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.locked_o  <= 1'b0;
      bus.fail_o    <= '0;
`ifdef ADC_DLY_CALIB_WIN_REPORT_EN
      bus.win_len_o <= '0;
`endif
    end else begin
      bus.dly_ld_o <= '0;
      bus.done_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state         <= S_LOAD;
            lane          <= '0;
            tap           <= '0;
            bus.busy_o    <= 1'b1;
            bus.locked_o  <= 1'b0;
            bus.fail_o    <= '0;
            bus.dly_tap_o <= '0;
            bus.dly_ld_o  <= ADC_DATA_WIDTH'(1);
`ifdef ADC_DLY_CALIB_WIN_REPORT_EN
            bus.win_len_o <= '0;
`endif
          end
        end
        S_LOAD: begin
          state      <= S_SETTLE;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
            state      <= S_CHECK;
            sample_cnt <= '0;
            err        <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          err <= err | (bus.adc_data_i[lane] != TRAIN_PATTERN[lane]);
          if (sample_cnt == NCW'(SAMPLE_CNT - 1)) state <= S_EVAL;
          else sample_cnt <= sample_cnt + 1'b1;
        end
        S_EVAL: begin
          cur_start    <= nxt_cur_start;
          cur_len      <= nxt_cur_len;
          best_start   <= nxt_best_start;
          best_len     <= nxt_best_len;
          bus.dly_ld_o <= ADC_DATA_WIDTH'(1) << lane;
          if (tap != TAP_WIDTH'(NUM_TAPS - 1)) begin
            state         <= S_LOAD;
            tap           <= tap + 1'b1;
            bus.dly_tap_o <= tap + 1'b1;
          end else begin
            state <= S_CENTER;
            if (nxt_best_len == '0) begin
              bus.dly_tap_o    <= '0;
              bus.fail_o[lane] <= 1'b1;
            end else begin
              bus.dly_tap_o <= nxt_best_start + TAP_WIDTH'(nxt_best_len >> 1);
            end
`ifdef ADC_DLY_CALIB_WIN_REPORT_EN
            bus.win_len_o[lane*LW +: LW] <= nxt_best_len;
`endif
          end
        end
        S_CENTER: begin
          state <= S_NEXT;
        end
        S_NEXT: begin
          cur_start  <= '0;
          cur_len    <= '0;
          best_start <= '0;
          best_len   <= '0;
          tap        <= '0;
          if (lane != LANE_W'(ADC_DATA_WIDTH - 1)) begin
            state         <= S_LOAD;
            lane          <= lane + 1'b1;
            bus.dly_tap_o <= '0;
            bus.dly_ld_o  <= ADC_DATA_WIDTH'(1) << (lane + 1'b1);
          end else begin
            state        <= S_DONE;
            bus.done_o   <= 1'b1;
            bus.busy_o   <= 1'b0;
            bus.locked_o <= ~|bus.fail_o;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dly_calib_ctrl.sv
// tb/tb_adc_dly_calib_ctrl.sv - directed self-checking bench for adc_dly_calib_ctrl
module tb_adc_dly_calib_ctrl;

  localparam logic [1:0] PAT = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pass0 = 8'h00;
  logic [7:0] pass1 = 8'h00;
  logic       glitch_en = 1'b0;
  logic [2:0] tap0 = '0;
  logic [2:0] tap1 = '0;
  int         since0 = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         lat;

  adc_dly_calib_ctrl_if #(.ADC_DATA_WIDTH(2), .TAP_WIDTH(3)) bus ();

  adc_dly_calib_ctrl #(
    .ADC_DATA_WIDTH(2), .TAP_WIDTH(3), .NUM_TAPS(8),
    .SETTLE_CYC(2), .SAMPLE_CNT(4), .TRAIN_PATTERN(PAT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Delay-line model: each lane latches the tap on its load strobe.
  always @(posedge clk) begin
    if (bus.dly_ld_o[0]) begin
      tap0   <= bus.dly_tap_o;
      since0 <= 0;
    end else begin
      since0 <= since0 + 1;
    end
    if (bus.dly_ld_o[1]) tap1 <= bus.dly_tap_o;
  end

  // Lane data: training bit inside the pass set, inverted outside; the
  // glitch flips one CHECK sample of lane 0 at tap 3.
  assign bus.adc_data_i[0] = (pass0[tap0] ? PAT[0] : ~PAT[0]) ^
                             (glitch_en && tap0 == 3'd3 && since0 == 3);
  assign bus.adc_data_i[1] = pass1[tap1] ? PAT[1] : ~PAT[1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tap"}, 32'(bus.dly_tap_o), 0);
    check({tag, "_ld"}, 32'(bus.dly_ld_o), 0);
    check({tag, "_busy"}, 32'(bus.busy_o), 0);
    check({tag, "_done"}, 32'(bus.done_o), 0);
    check({tag, "_locked"}, 32'(bus.locked_o), 0);
    check({tag, "_fail"}, 32'(bus.fail_o), 0);
  endtask

  // Called at a negedge; returns at the negedge of the done_o cycle.
  task automatic run_cal(input int repulse_at, output int latency);
    latency = -1;
    bus.start_i = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      bus.start_i = (n == repulse_at);
      if (n == 1) begin
        check("busy_after_start", 32'(bus.busy_o), 1);
        check("locked_cleared", 32'(bus.locked_o), 0);
      end
      if (bus.done_o) begin
        latency = n;
        break;
      end
    end
    check("done_latency", 32'(latency), 133);
    check("busy_in_done", 32'(bus.busy_o), 0);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("done_one_pulse", 32'(bus.done_o), 0);
    check("start_in_done_ignored", 32'(bus.busy_o), 0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    // Lane0 taps 2-5, lane1 all taps; start re-pulsed while busy.
    pass0 = 8'b0011_1100;
    pass1 = 8'hFF;
    run_cal(50, lat);
    check("a_tap0", 32'(tap0), 4);
    check("a_tap1", 32'(tap1), 4);
    check("a_locked", 32'(bus.locked_o), 1);
    check("a_fail", 32'(bus.fail_o), 0);
`ifdef ADC_DLY_CALIB_WIN_REPORT_EN
    check("a_win_len", 32'(bus.win_len_o), 32'h84);
`endif

    // {1,2} and {4,5,6}, tap 3 killed by a single bad sample.
    pass0 = 8'b0111_1110;
    glitch_en = 1'b1;
    run_cal(0, lat);
    check("b_tap0", 32'(tap0), 5);
    check("b_locked", 32'(bus.locked_o), 1);
    glitch_en = 1'b0;

    // Equal-length windows {1,2} and {5,6}: earlier one wins.
    pass0 = 8'b0110_0110;
    run_cal(0, lat);
    check("tie_tap0", 32'(tap0), 2);

    // Lane1 never passes.
    pass0 = 8'b0011_1100;
    pass1 = 8'h00;
    run_cal(0, lat);
    check("f_tap0", 32'(tap0), 4);
    check("f_tap1", 32'(tap1), 0);
    check("f_fail", 32'(bus.fail_o), 2);
    check("f_locked", 32'(bus.locked_o), 0);

    // Reset during lane0 tap0 CHECK, then a full recalibration.
    pass1 = 8'hFF;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_idle", 32'(bus.busy_o), 0);
    run_cal(0, lat);
    check("r_tap0", 32'(tap0), 4);
    check("r_tap1", 32'(tap1), 4);
    check("r_locked", 32'(bus.locked_o), 1);
`ifdef ADC_DLY_CALIB_WIN_REPORT_EN
    check("r_win_len", 32'(bus.win_len_o), 32'h84);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_dly_calib_ctrl.md
Name: adc_dly_calib_ctrl

Overview:
- Per-bit input-delay calibration sequencer for the differential ADC data lanes, placed after the IBUFDS buffers and the per-lane IDELAY elements.
- Driven by `start`, it runs one lane at a time:
  - sweeps every delay tap on that lane;
  - compares the lane against the ADC's fixed training pattern;
  - finds the longest contiguous error-free tap window;
  - loads the tap at the centre of that window.
- Reports busy, done, lock and per-lane failure status to the control logic.

Parameters:
- ADC_DATA_WIDTH, 8, number of ADC data lanes.
- TAP_WIDTH, 5, width of one IDELAY tap value.
- NUM_TAPS, 32, taps swept per lane, 0..NUM_TAPS-1; NUM_TAPS ≤ 2^TAP_WIDTH.
- SETTLE_CYC, 16, idle cycles after each tap load before sampling starts (≥1).
- SAMPLE_CNT, 256, samples compared per tap (≥1).
- TRAIN_PATTERN, 8'hA5, expected ADC word in test-pattern mode; width is ADC_DATA_WIDTH.

Ports:
- clk  in  1  ADC data-domain clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to begin calibration; ignored while busy_o=1.
- adc_data_i  in  ADC_DATA_WIDTH  buffered and delayed ADC word, one sample per clk.
- dly_tap_o  out  TAP_WIDTH  tap value presented to the delay elements.
- dly_ld_o  out  ADC_DATA_WIDTH  one-hot, one-cycle load strobe; lane i latches dly_tap_o when bit i=1.
- busy_o  out  1  high while calibration is in progress.
- done_o  out  1  one-cycle pulse when calibration completes.
- locked_o  out  1  high after a calibration in which every lane found a window.
- fail_o  out  ADC_DATA_WIDTH  bit i=1 when lane i had no error-free tap.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state→IDLE;
  - dly_tap_o=0, dly_ld_o=0, busy_o=0, done_o=0, locked_o=0, fail_o=0;
  - all counters and window registers cleared.
- Reset mid-calibration abandons the sweep immediately. Delay taps are left wherever they were last loaded.
- States and transitions:
  - IDLE: on start_i=1 → LOAD. Lane=0, tap=0. busy_o=1 from the next cycle. locked_o and fail_o cleared.
  - LOAD: dly_tap_o=tap, dly_ld_o=1<<lane for exactly 1 cycle → SETTLE. Settle counter cleared.
  - SETTLE: count SETTLE_CYC cycles → CHECK. Sample counter cleared, error flag cleared.
  - CHECK: for SAMPLE_CNT cycles set err |= (adc_data_i[lane] != TRAIN_PATTERN[lane]) → EVAL.
  - EVAL (1 cycle), window update:
    - pass (err=0): if cur_len=0 then cur_start=tap; cur_len=cur_len+1.
    - If the new cur_len > best_len (strictly greater), then best_start=cur_start and best_len=new cur_len. Ties keep the earlier window.
    - fail (err=1): cur_len=0.
    - If tap<NUM_TAPS-1: tap+1 → LOAD. Otherwise → CENTER.
  - CENTER: load the chosen tap via the LOAD pulse mechanism, 1 cycle.
    - If best_len>0: load best_start + (best_len>>1).
    - If best_len=0: load tap 0 and set fail_o[lane]=1.
    - Then → NEXT.
  - NEXT: clear cur/best registers and tap.
    - If lane<ADC_DATA_WIDTH-1: lane+1 → LOAD.
    - Otherwise → DONE.
  - DONE: done_o=1 for 1 cycle, busy_o=0, locked_o=~|fail_o → IDLE.
- Widths:
  - cur_len and best_len are TAP_WIDTH+1 bits, so a window equal to NUM_TAPS=2^TAP_WIDTH does not overflow.
  - The centre sum fits in TAP_WIDTH bits.
- Boundary cases:
  - A window still open at the last tap is closed by the final EVAL compare; no wrap-around across tap 0.
  - All taps passing gives centre NUM_TAPS/2.
  - A start_i arriving in the same cycle as done_o is ignored; start_i is accepted in IDLE only.
- Latency:
  - Per tap: 1 + SETTLE_CYC + SAMPLE_CNT + 1 cycles.
  - Per lane: NUM_TAPS × that + 2.
  - Total: ADC_DATA_WIDTH × per-lane + 1 (DONE) cycles after start acceptance.

Optional Feature:
- Macro: ADC_DLY_CALIB_WIN_REPORT_EN.
- Defined:
  - Adds output win_len_o, ADC_DATA_WIDTH×(TAP_WIDTH+1) bits.
  - Slice i holds lane i's best_len, latched in CENTER.
  - Cleared on rst and on start acceptance; holds its value after DONE.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Common bench parameters: ADC_DATA_WIDTH=2, NUM_TAPS=8, SETTLE_CYC=2, SAMPLE_CNT=4, TRAIN_PATTERN=2'b01. The bench model corrupts lane i at taps outside its configured pass set.
- Lane0 passes taps 2–5, lane1 passes taps 0–7 → lane0 final load tap 4, lane1 tap 4; locked_o=1, fail_o=0; done_o one pulse exactly 2×(8×8+2)+1=133 cycles after start acceptance.
- Lane0 passes {1,2} and {4,5,6}; a single corrupted sample at tap 3 → centre 5; tie case {1,2} and {5,6} → centre 2.
- Lane1 never passes → lane1 loads tap 0, fail_o=2'b10, locked_o=0, done_o still pulses.
- start_i re-pulsed while busy → ignored, identical timing. rst asserted mid-CHECK → next cycle all outputs 0, state IDLE; a new start_i runs a full calibration.
- With ADC_DLY_CALIB_WIN_REPORT_EN defined, first scenario → win_len_o = {4'd8, 4'd4}.
